switch_merge: RTL

//  Return-path counterpart of the address-split switch. Merges the two port

---
 rtl/switch_pkg.sv | 18 +
 rtl/switch_merge_fifo.sv | 67 ++++++
 rtl/switch_merge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared definitions for the address-split switch and its merge counterpart.
// Holds the default address/data widths, the A/B address boundary and the
// packet type carried through the merge FIFOs.
package switch_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  localparam int FIFO_DEPTH = 4;

  // Last address owned by port A; port B owns everything above it.
  localparam logic [ADDR_WIDTH-1:0] ADDR_DIV = 8'd100;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } switch_pkt_t;

endpackage

// File: rtl/switch_merge_fifo.sv
// Synchronous FIFO of switch_pkt_t used as the per-port input buffer of
// switch_merge.
// Ports:
//   clk   - clock, rising edge
//   rstn  - synchronous reset, active low (empties the FIFO)
//   push  - write din (ignored while full)
//   din   - packet to write
//   pop   - advance the read pointer (ignored while empty)
//   dout  - packet at the head of the FIFO
//   full  - no free entry
//   empty - no stored entry
module switch_merge_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  switch_pkt_t din,
  input  logic        pop,
  output switch_pkt_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  switch_pkt_t mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/switch_merge.sv
// Return-path merge of the address-split switch. Port A (addresses up to
// ADDR_DIV) and port B (addresses above ADDR_DIV) are each buffered in a
// FIFO, arbitrated round-robin and driven out through one registered
// valid/ready stage. Packets arriving on the wrong port are consumed,
// dropped and counted in a saturating error counter.
// Ports:
//   clk, rstn                 - clock (rising edge), synchronous active-low reset
//   vld_a, addr_a, data_a     - port A packet in; rdy_a = FIFO A not full
//   vld_b, addr_b, data_b     - port B packet in; rdy_b = FIFO B not full
//   vld_out, addr_out,
//   data_out, rdy_out         - registered merged output with downstream ready
//   err_cnt                   - misrouted packet count, saturates at 255
// Widths come from switch_pkg so the FIFO packet type and the ports agree.
module switch_merge
  import switch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] ADDR_DIV_P = ADDR_DIV,
  parameter int                    FIFO_DEPTH_P = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  vld_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  rdy_a,
  input  logic                  vld_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  rdy_b,
  output logic                  vld_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rdy_out,
  output logic [7:0]            err_cnt
);

  switch_pkt_t pkt_a, pkt_b;
  switch_pkt_t head_a, head_b;
  logic        full_a, full_b;
  logic        empty_a, empty_b;
  logic        acc_a, acc_b;
  logic        push_a, push_b;
  logic        mis_a, mis_b;
  logic        pop_a, pop_b;
  logic        load;

  logic        vld_out_q, vld_out_d;
  switch_pkt_t pkt_out_q, pkt_out_d;
  logic        last_b_q, last_b_d;   // 1: B was granted last, so A wins a tie
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [8:0]  err_sum;

  // Gated with rstn so no handshake is advertised during reset.
  assign rdy_a = rstn && !full_a;
  assign rdy_b = rstn && !full_b;

  assign acc_a  = vld_a && rdy_a;
  assign acc_b  = vld_b && rdy_b;
  assign push_a = acc_a && (addr_a <= ADDR_DIV_P);
  assign push_b = acc_b && (addr_b >  ADDR_DIV_P);
  assign mis_a  = acc_a && !(addr_a <= ADDR_DIV_P);
  assign mis_b  = acc_b && !(addr_b >  ADDR_DIV_P);

  assign pkt_a = '{addr: addr_a, data: data_a};
  assign pkt_b = '{addr: addr_b, data: data_b};

  switch_merge_fifo #(.DEPTH(FIFO_DEPTH_P)) u_fifo_a (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_a),
    .din   (pkt_a),
    .pop   (pop_a),
    .dout  (head_a),
    .full  (full_a),
    .empty (empty_a)
  );

  switch_merge_fifo #(.DEPTH(FIFO_DEPTH_P)) u_fifo_b (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_b),
    .din   (pkt_b),
    .pop   (pop_b),
    .dout  (head_b),
    .full  (full_b),
    .empty (empty_b)
  );

  // The output register can take a new packet when empty or when its
  // current packet is handed off this cycle.
  assign load = !vld_out_q || rdy_out;

  always_comb begin
    pop_a     = 1'b0;
    pop_b     = 1'b0;
    vld_out_d = vld_out_q;
    pkt_out_d = pkt_out_q;
    last_b_d  = last_b_q;

    if (load) begin
      if (!empty_a && !empty_b) begin
        pop_a = last_b_q;
        pop_b = !last_b_q;
      end else begin
        pop_a = !empty_a;
        pop_b = !empty_b;
      end

      vld_out_d = pop_a || pop_b;
      if (pop_a) begin
        pkt_out_d = head_a;
        last_b_d  = 1'b0;
      end else if (pop_b) begin
        pkt_out_d = head_b;
        last_b_d  = 1'b1;
      end
    end
  end

  // Both ports may misroute in the same cycle, so add up to 2 and clamp.
  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + {8'b0, mis_a} + {8'b0, mis_b};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_out_q <= 1'b0;
      pkt_out_q <= '0;
      last_b_q  <= 1'b1;
      err_cnt_q <= '0;
    end else begin
      vld_out_q <= vld_out_d;
      pkt_out_q <= pkt_out_d;
      last_b_q  <= last_b_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign vld_out  = vld_out_q;
  assign addr_out = pkt_out_q.addr;
  assign data_out = pkt_out_q.data;
  assign err_cnt  = err_cnt_q;

endmodule
